// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared types and constants for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int c_WIDTH = 8;
    localparam int c_AW    = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    // The counter must be able to hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int c_CNT_W = cnt_width(c_WIDTH);

endpackage : mult_pkg
`default_nettype wire

// File: rtl/shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module      : shift_add_dp
// Description : Shift-add product register; one unsigned iteration per step.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_a_data,
    input  logic [WIDTH-1:0]   i_b_data,
    output logic [2*WIDTH-1:0] o_product
);

    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]     w_hi;

    // The extra top bit keeps the carry so the shift never loses it.
    always_comb begin
        w_hi = {1'b0, r_p[2*WIDTH-1:WIDTH]};
        if (r_p[0]) begin
            w_hi = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p     <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_mcand <= i_a_data;
            r_p     <= {{WIDTH{1'b0}}, i_b_data};
        end else if (i_step) begin
            r_p     <= {w_hi, r_p[WIDTH-1:1]};
        end
    end

    assign o_product = r_p;

endmodule : shift_add_dp
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Register-file sequencer for an unsigned shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = c_WIDTH,
    parameter int AW    = c_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rd,
    output logic [AW-1:0]    A_addr,
    output logic [AW-1:0]    B_addr,
    input  logic [WIDTH-1:0] A_data,
    input  logic [WIDTH-1:0] B_data,
    output logic [AW-1:0]    W_addr,
    output logic [WIDTH-1:0] W_data,
    output logic             wr,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_ra;
    logic [AW-1:0]      r_rb;
    logic [AW-1:0]      r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;
    logic               w_load;
    logic               w_step;
    logic [2*WIDTH-1:0] w_product;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_load = (r_state == LOAD);
    assign w_step = (r_state == MUL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_ra <= ra;
                r_rb <= rb;
                r_rd <= rd;
            end
            if (r_state == LOAD) begin
                r_cnt <= '0;
            end else if (r_state == MUL) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = LOAD;
            LOAD:    w_next = MUL;
            MUL:     if (w_last) w_next = WR_LO;
            WR_LO:   w_next = WR_HI;
            WR_HI:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Write port is decoded from state and held registers only.
    always_comb begin
        wr     = 1'b0;
        W_addr = '0;
        W_data = '0;
        case (r_state)
            WR_LO: begin
                wr     = 1'b1;
                W_addr = r_rd;
                W_data = w_product[WIDTH-1:0];
            end
            WR_HI: begin
                wr     = 1'b1;
                W_addr = r_rd + AW'(1);
                W_data = w_product[2*WIDTH-1:WIDTH];
            end
            default: begin
                wr     = 1'b0;
                W_addr = '0;
                W_data = '0;
            end
        endcase
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign A_addr = r_ra;
    assign B_addr = r_rb;

    shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_a_data  (A_data),
        .i_b_data  (B_data),
        .o_product (w_product)
    );

endmodule : mult_seq_ctrl
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Directed scoreboard bench for mult_seq_ctrl with an RF model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] ra = '0, rb = '0, rd = '0;
    logic [3:0] A_addr, B_addr, W_addr;
    logic [7:0] A_data, B_data, W_data;
    logic       wr, busy, done;

    logic [7:0] rf [16];
    logic [7:0] snap [16];
    logic       tb_we = 1'b0;
    logic [3:0] tb_addr = '0;
    logic [7:0] tb_data = '0;

    logic [12:0] sb [$];
    int n_pass  = 0;
    int n_total = 0;
    int n_wr    = 0;
    int n_done  = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .ra     (ra),
        .rb     (rb),
        .rd     (rd),
        .A_addr (A_addr),
        .B_addr (B_addr),
        .A_data (A_data),
        .B_data (B_data),
        .W_addr (W_addr),
        .W_data (W_data),
        .wr     (wr),
        .busy   (busy),
        .done   (done)
    );

    assign A_data = rf[A_addr];
    assign B_data = rf[B_addr];

    always @(posedge clk) begin
        if (wr) rf[W_addr] <= W_data;
        else if (tb_we) rf[tb_addr] <= tb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Each write is matched against the oldest expected write; bit 12 marks "none expected".
    always @(negedge clk) begin
        logic [12:0] exp_w;
        if (done === 1'b1) n_done++;
        if (wr === 1'b1) begin
            n_wr++;
            exp_w = (sb.size() > 0) ? sb.pop_front() : 13'h1FFF;
            check("rf_write", 32'({1'b0, W_addr, W_data}), 32'(exp_w));
        end
    end

    task automatic set_reg(input logic [3:0] a, input logic [7:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic take_snap();
        for (int i = 0; i < 16; i++) snap[i] = rf[i];
    endtask

    function automatic int count_diff(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (rf[i] !== snap[i]) n++;
        return n;
    endfunction

    task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                           input int extra_cyc, input int rst_cyc, input int tail);
        logic [15:0] prod;
        int cyc, wr0, done0;
        prod  = 16'(rf[a]) * 16'(rf[b]);
        wr0   = n_wr;
        done0 = n_done;
        if (rst_cyc == 0) begin
            sb.push_back({1'b0, d, prod[7:0]});
            sb.push_back({1'b0, d + 4'd1, prod[15:8]});
        end
        @(negedge clk);
        ra = a; rb = b; rd = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check("busy_load", 32'(busy), 32'd1);
        check("a_addr", 32'(A_addr), 32'(a));
        check("b_addr", 32'(B_addr), 32'(b));
        while (done !== 1'b1 && cyc < 40) begin
            start = (cyc == extra_cyc);
            if (start) begin ra = a + 4'd5; rb = b + 4'd3; rd = d + 4'd7; end
            rst = (rst_cyc != 0 && cyc == rst_cyc);
            @(negedge clk);
            cyc++;
            if (rst_cyc != 0 && cyc > rst_cyc) break;
        end
        start = 1'b0;
        if (rst_cyc != 0) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_wr", 32'(wr), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            rst = 1'b0;
        end else begin
            check("done_latency", 32'(cyc), 32'd12);
            @(negedge clk);
            check("done_one_cycle", 32'({done, busy}), 32'd0);
        end
        repeat (tail) @(negedge clk);
        check("wr_count", 32'(n_wr - wr0), (rst_cyc != 0) ? 32'd0 : 32'd2);
        check("done_count", 32'(n_done - done0), (rst_cyc != 0) ? 32'd0 : 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 16; i++) set_reg(4'(i), 8'(8'h30 + i));
        @(negedge clk);
        check("reset_ctrl", 32'({busy, done, wr}), 32'd0);
        check("reset_waddr_wdata", 32'({W_addr, W_data}), 32'd0);
        check("reset_ab_addr", 32'({A_addr, B_addr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 7 x 9
        set_reg(4'd1, 8'd7);
        set_reg(4'd2, 8'd9);
        run_cmd(4'd1, 4'd2, 4'd4, 0, 0, 2);
        check("r4_7x9", 32'(rf[4]), 32'h3F);
        check("r5_7x9", 32'(rf[5]), 32'h00);

        // 255 x 255
        set_reg(4'd1, 8'hFF);
        set_reg(4'd2, 8'hFF);
        run_cmd(4'd1, 4'd2, 4'd6, 0, 0, 2);
        check("r6_ffxff", 32'(rf[6]), 32'h01);
        check("r7_ffxff", 32'(rf[7]), 32'hFE);

        // Zero operand, rd wraps to register 0
        set_reg(4'd3, 8'h00);
        set_reg(4'd8, 8'hA5);
        set_reg(4'd0, 8'h55);
        set_reg(4'd15, 8'h77);
        take_snap();
        run_cmd(4'd3, 4'd8, 4'd15, 0, 0, 2);
        check("r15_wrap", 32'(rf[15]), 32'h00);
        check("r0_wrap", 32'(rf[0]), 32'h00);
        check("r1_14_unchanged", 32'(count_diff(1, 14)), 32'd0);

        // Second start while busy is ignored
        set_reg(4'd9, 8'd12);
        set_reg(4'd10, 8'd11);
        run_cmd(4'd9, 4'd10, 4'd12, 3, 0, 16);
        check("r12_busy_start", 32'(rf[12]), 32'd132);
        check("r13_busy_start", 32'(rf[13]), 32'd0);

        // Reset during the fifth MUL cycle abandons the command
        take_snap();
        run_cmd(4'd1, 4'd2, 4'd10, 0, 6, 4);
        check("rst_no_write", 32'(count_diff(0, 15)), 32'd0);
        set_reg(4'd4, 8'd3);
        set_reg(4'd5, 8'd5);
        run_cmd(4'd4, 4'd5, 4'd11, 0, 0, 2);
        check("r11_3x5", 32'(rf[11]), 32'h0F);
        check("r12_3x5", 32'(rf[12]), 32'h00);

        // Destination overlaps a source
        set_reg(4'd2, 8'h10);
        set_reg(4'd3, 8'h10);
        run_cmd(4'd2, 4'd3, 4'd2, 0, 0, 2);
        check("r2_overlap", 32'(rf[2]), 32'h00);
        check("r3_overlap", 32'(rf[3]), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mult_seq_ctrl
`default_nettype wire
